// File: rtl/gearbox_pkg.sv
// Shared types, per-gear tables and lookup for the gearbox speed controller.
// Tables are indexed by 1-based gear; entry 0 is unused.
package gearbox_pkg;

    localparam int TBL_W     = 8;
    localparam int TBL_DEPTH = 8;

    typedef enum logic [0:0] {
        DRIVE = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef struct packed {
        logic [TBL_W-1:0] accel;
        logic [TBL_W-1:0] brake;
        logic [TBL_W-1:0] up;
        logic [TBL_W-1:0] dn;
    } gear_params_t;

    localparam logic [TBL_W-1:0] ACCEL_TBL [TBL_DEPTH] =
        '{8'd0, 8'd5, 8'd3, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1};
    localparam logic [TBL_W-1:0] BRAKE_TBL [TBL_DEPTH] =
        '{8'd0, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1};
    // UP of the top gear and DN of gear 1 are never consulted.
    localparam logic [TBL_W-1:0] UP_TBL [TBL_DEPTH] =
        '{8'd0, 8'd40, 8'd60, 8'd80, 8'd90, 8'd95, 8'd98, 8'd0};
    localparam logic [TBL_W-1:0] DN_TBL [TBL_DEPTH] =
        '{8'd0, 8'd0, 8'd27, 8'd55, 8'd75, 8'd85, 8'd92, 8'd96};

    function automatic gear_params_t gear_lookup(input logic [2:0] g);
        gear_params_t p;
        p.accel = ACCEL_TBL[g];
        p.brake = BRAKE_TBL[g];
        p.up    = UP_TBL[g];
        p.dn    = DN_TBL[g];
        return p;
    endfunction

endpackage

// File: rtl/gearbox_speed_step.sv
// Combinational saturating speed update: applies a signed delta to the speed
// and clamps the result to [0, cap] without wrap-around.
module speed_step
    import gearbox_pkg::*;
#(
    parameter int SPEED_W = 7
) (
    input  logic [SPEED_W-1:0]      i_speed,
    input  logic signed [TBL_W-1:0] i_delta,
    input  logic [SPEED_W-1:0]      i_cap,
    output logic [SPEED_W-1:0]      o_speed
);

    logic signed [TBL_W-1:0] w_neg;
    logic [TBL_W-1:0]        w_mag;
    logic [SPEED_W:0]        w_mag_ext;
    logic [SPEED_W:0]        w_sum;
    logic [SPEED_W:0]        w_diff;

    assign w_neg     = -i_delta;
    assign w_mag     = i_delta[TBL_W-1] ? w_neg : i_delta;
    assign w_mag_ext = (SPEED_W+1)'(w_mag);
    assign w_sum     = {1'b0, i_speed} + w_mag_ext;
    assign w_diff    = {1'b0, i_speed} - w_mag_ext;

    // Borrow shows up in the extra MSB; gas never pulls an over-cap speed down.
    always_comb begin
        o_speed = i_speed;
        if (i_delta[TBL_W-1]) begin
            if (w_diff[SPEED_W]) begin
                o_speed = {SPEED_W{1'b0}};
            end else begin
                o_speed = w_diff[SPEED_W-1:0];
            end
        end else if (w_sum > {1'b0, i_cap}) begin
            if (i_speed > i_cap) begin
                o_speed = i_speed;
            end else begin
                o_speed = i_cap;
            end
        end else begin
            o_speed = w_sum[SPEED_W-1:0];
        end
    end

endmodule

// File: rtl/gearbox_speed_controller.sv
// Vehicle speed/gear controller: integrates pedals into a saturating speed and
// runs an N-speed gearbox (auto or manual) through a timed clutch state.
module gearbox_speed_controller
    import gearbox_pkg::*;
#(
    parameter int NUM_GEARS    = 4,
    parameter int SPEED_W      = 7,
    parameter int MAX_SPEED    = 100,
    parameter int SHIFT_CYCLES = 2,
    parameter int COAST_PERIOD = 8,
    parameter int GEAR_W       = $clog2(NUM_GEARS + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               gas,
    input  logic               brake,
    input  logic               manual_mode,
    input  logic               shift_up_req,
    input  logic               shift_down_req,
    output logic [SPEED_W-1:0] speed,
    output logic [GEAR_W-1:0]  gear,
    output logic               shifting,
    output logic               shift_reject
);

    localparam int CMP_W   = (SPEED_W > TBL_W) ? SPEED_W : TBL_W;
    localparam int COAST_W = $clog2(COAST_PERIOD + 1);
    localparam int SCNT_W  = $clog2(SHIFT_CYCLES + 1);

    state_e              r_state,     w_state_nxt;
    logic [GEAR_W-1:0]   r_gear,      w_gear_nxt;
    logic [GEAR_W-1:0]   r_target,    w_target_nxt;
    logic [SPEED_W-1:0]  r_speed,     w_speed_nxt;
    logic [COAST_W-1:0]  r_coast_cnt, w_coast_nxt;
    logic [SCNT_W-1:0]   r_shift_cnt, w_shift_cnt_nxt;
    logic                r_shifting,  w_shifting_nxt;
    logic                r_reject,    w_reject_nxt;

    gear_params_t            w_cur;
    logic [2:0]              w_gidx;
    logic [2:0]              w_gidx_up;
    logic [2:0]              w_gidx_dn;
    logic [CMP_W-1:0]        w_speed_c;
    logic [CMP_W-1:0]        w_cap_c;
    logic [SPEED_W-1:0]      w_cap;
    logic                    w_top;
    logic                    w_up_room;
    logic                    w_dn_room;
    logic                    w_stall;
    logic                    w_auto_up;
    logic                    w_man_up_ok;
    logic                    w_man_dn_ok;
    logic                    w_coast_hit;
    logic signed [TBL_W-1:0] w_delta;
    logic [COAST_W-1:0]      w_coast_drive;
    logic [SPEED_W-1:0]      w_step_speed;
    logic                    w_take;
    logic                    w_take_up;

    assign w_gidx    = 3'(r_gear);
    assign w_gidx_up = w_gidx + 3'd1;
    assign w_gidx_dn = w_gidx - 3'd1;
    assign w_cur     = gear_lookup(w_gidx);
    assign w_speed_c = CMP_W'(r_speed);

    assign w_top       = (r_gear == GEAR_W'(NUM_GEARS));
    assign w_up_room   = (r_gear < GEAR_W'(NUM_GEARS));
    assign w_dn_room   = (r_gear > GEAR_W'(1));
    assign w_stall     = w_dn_room && (w_speed_c < CMP_W'(w_cur.dn));
    assign w_auto_up   = w_up_room && (w_speed_c >= CMP_W'(w_cur.up));
    assign w_man_up_ok = w_up_room && (w_speed_c >= CMP_W'(DN_TBL[w_gidx_up]));
    assign w_man_dn_ok = w_dn_room && (w_speed_c < CMP_W'(UP_TBL[w_gidx_dn]));
    assign w_coast_hit = (r_coast_cnt == COAST_W'(COAST_PERIOD - 1));

    // Manual mode below the top gear acts as a rev limiter at the up-shift point.
    always_comb begin
        w_cap_c = CMP_W'(MAX_SPEED);
        if (manual_mode && !w_top && (CMP_W'(w_cur.up) < CMP_W'(MAX_SPEED))) begin
            w_cap_c = CMP_W'(w_cur.up);
        end else begin
            w_cap_c = CMP_W'(MAX_SPEED);
        end
        w_cap = SPEED_W'(w_cap_c);
    end

    // Pedal decode into a speed delta, plus the coast counter advance.
    always_comb begin
        w_delta       = 8'sd0;
        w_coast_drive = {COAST_W{1'b0}};
        if (gas && !brake) begin
            w_delta = $signed(w_cur.accel);
        end else if (brake && !gas) begin
            w_delta = -$signed(w_cur.brake);
        end else if (gas && brake) begin
            w_delta = -8'sd1;
        end else if (w_coast_hit) begin
            w_delta = -8'sd1;
        end else begin
            w_coast_drive = r_coast_cnt + COAST_W'(1);
        end
    end

    speed_step #(
        .SPEED_W (SPEED_W)
    ) u_speed_step (
        .i_speed (r_speed),
        .i_delta (w_delta),
        .i_cap   (w_cap),
        .o_speed (w_step_speed)
    );

    // Next-state logic: shift decisions take priority over pedal updates.
    always_comb begin
        w_state_nxt     = r_state;
        w_gear_nxt      = r_gear;
        w_target_nxt    = r_target;
        w_speed_nxt     = r_speed;
        w_coast_nxt     = r_coast_cnt;
        w_shift_cnt_nxt = r_shift_cnt;
        w_shifting_nxt  = r_shifting;
        w_reject_nxt    = 1'b0;
        w_take          = 1'b0;
        w_take_up       = 1'b0;
        case (r_state)
            DRIVE: begin
                if (manual_mode) begin
                    if (w_stall) begin
                        w_take = 1'b1;
                    end else if (shift_up_req && shift_down_req) begin
                        w_reject_nxt = 1'b1;
                    end else if (shift_up_req) begin
                        w_take       = w_man_up_ok;
                        w_take_up    = w_man_up_ok;
                        w_reject_nxt = !w_man_up_ok;
                    end else if (shift_down_req) begin
                        w_take       = w_man_dn_ok;
                        w_reject_nxt = !w_man_dn_ok;
                    end else begin
                        w_take = 1'b0;
                    end
                end else if (w_auto_up) begin
                    w_take    = 1'b1;
                    w_take_up = 1'b1;
                end else begin
                    w_take = w_stall;
                end

                if (w_take) begin
                    w_state_nxt     = SHIFT;
                    w_shifting_nxt  = 1'b1;
                    w_shift_cnt_nxt = {SCNT_W{1'b0}};
                    if (w_take_up) begin
                        w_target_nxt = r_gear + GEAR_W'(1);
                    end else begin
                        w_target_nxt = r_gear - GEAR_W'(1);
                    end
                end else begin
                    w_speed_nxt = w_step_speed;
                    w_coast_nxt = w_coast_drive;
                end
            end
            SHIFT: begin
                w_reject_nxt = manual_mode && (shift_up_req || shift_down_req);
                if (r_shift_cnt == SCNT_W'(SHIFT_CYCLES - 1)) begin
                    w_state_nxt     = DRIVE;
                    w_gear_nxt      = r_target;
                    w_shifting_nxt  = 1'b0;
                    w_shift_cnt_nxt = {SCNT_W{1'b0}};
                end else begin
                    w_shift_cnt_nxt = r_shift_cnt + SCNT_W'(1);
                end
            end
            default: begin
                w_state_nxt    = DRIVE;
                w_shifting_nxt = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset mid-shift discards the target gear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= DRIVE;
            r_gear      <= GEAR_W'(1);
            r_target    <= GEAR_W'(1);
            r_speed     <= {SPEED_W{1'b0}};
            r_coast_cnt <= {COAST_W{1'b0}};
            r_shift_cnt <= {SCNT_W{1'b0}};
            r_shifting  <= 1'b0;
            r_reject    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gear      <= w_gear_nxt;
            r_target    <= w_target_nxt;
            r_speed     <= w_speed_nxt;
            r_coast_cnt <= w_coast_nxt;
            r_shift_cnt <= w_shift_cnt_nxt;
            r_shifting  <= w_shifting_nxt;
            r_reject    <= w_reject_nxt;
        end
    end

    assign speed        = r_speed;
    assign gear         = r_gear;
    assign shifting     = r_shifting;
    assign shift_reject = r_reject;

endmodule

// File: tb/tb_gearbox_speed_controller.sv
// Directed testbench for gearbox_speed_controller with default parameters.
module tb_gearbox_speed_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       gas;
    logic       brake;
    logic       manual_mode;
    logic       shift_up_req;
    logic       shift_down_req;
    logic [6:0] speed;
    logic [2:0] gear;
    logic       shifting;
    logic       shift_reject;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic g;
        logic b;
        logic m;
        logic u;
        logic d;
        int   s;
        int   gr;
        logic sh;
        logic rj;
    } vec_t;

    vec_t q[$];

    gearbox_speed_controller dut (
        .clock          (clock),
        .reset          (reset),
        .gas            (gas),
        .brake          (brake),
        .manual_mode    (manual_mode),
        .shift_up_req   (shift_up_req),
        .shift_down_req (shift_down_req),
        .speed          (speed),
        .gear           (gear),
        .shifting       (shifting),
        .shift_reject   (shift_reject)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic g, input logic b, input logic m, input logic u,
                        input logic d, input int s, input int gr, input logic sh, input logic rj);
        q.push_back('{g, b, m, u, d, s, gr, sh, rj});
    endtask

    task automatic apply_reset();
        reset = 1'b1; gas = 1'b0; brake = 1'b0; manual_mode = 1'b0;
        shift_up_req = 1'b0; shift_down_req = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; gas = 1'b0; brake = 1'b0; manual_mode = 1'b0;
        shift_up_req = 1'b0; shift_down_req = 1'b0;
        #1;
        n_tests++;
        if ({speed, gear, shifting, shift_reject} !== {7'd0, 3'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got speed=%0d gear=%0d shifting=%b reject=%b, want 0 1 0 0",
                     speed, gear, shifting, shift_reject);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_auto_upshift();
        apply_reset();
        for (int i = 1; i <= 8; i++) push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5 * i, 1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40, 1, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40, 1, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40, 2, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 43, 2, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 46, 2, 1'b0, 1'b0);
        foreach (q[i]) begin
            gas = q[i].g; brake = q[i].b; manual_mode = q[i].m;
            shift_up_req = q[i].u; shift_down_req = q[i].d;
            tick();
            n_tests++;
            if (speed !== 7'(q[i].s) || gear !== 3'(q[i].gr) || shifting !== q[i].sh || shift_reject !== q[i].rj) begin
                n_fail++;
                $display("FAIL auto_upshift step %0d: got speed=%0d gear=%0d shifting=%b reject=%b, want speed=%0d gear=%0d shifting=%b reject=%b",
                         i, speed, gear, shifting, shift_reject, q[i].s, q[i].gr, q[i].sh, q[i].rj);
            end
        end
        q.delete();
    endtask

    task automatic test_auto_downshift();
        int e;
        for (int k = 1; k <= 10; k++) push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 46 - 2 * k, 2, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26, 2, 1'b1, 1'b0);
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26, 2, 1'b1, 1'b0);
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26, 1, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            e = 26 - 3 * k;
            if (e < 0) e = 0;
            push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e, 1, 1'b0, 1'b0);
        end
        foreach (q[i]) begin
            gas = q[i].g; brake = q[i].b; manual_mode = q[i].m;
            shift_up_req = q[i].u; shift_down_req = q[i].d;
            tick();
            n_tests++;
            if (speed !== 7'(q[i].s) || gear !== 3'(q[i].gr) || shifting !== q[i].sh || shift_reject !== q[i].rj) begin
                n_fail++;
                $display("FAIL auto_downshift step %0d: got speed=%0d gear=%0d shifting=%b reject=%b, want speed=%0d gear=%0d shifting=%b reject=%b",
                         i, speed, gear, shifting, shift_reject, q[i].s, q[i].gr, q[i].sh, q[i].rj);
            end
        end
        q.delete();
    endtask

    task automatic test_manual_limiter();
        apply_reset();
        for (int i = 1; i <= 11; i++) push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, (5 * i > 40) ? 40 : 5 * i, 1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 40, 1, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 40, 1, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 40, 2, 1'b0, 1'b0);
        foreach (q[i]) begin
            gas = q[i].g; brake = q[i].b; manual_mode = q[i].m;
            shift_up_req = q[i].u; shift_down_req = q[i].d;
            tick();
            n_tests++;
            if (speed !== 7'(q[i].s) || gear !== 3'(q[i].gr) || shifting !== q[i].sh || shift_reject !== q[i].rj) begin
                n_fail++;
                $display("FAIL manual_limiter step %0d: got speed=%0d gear=%0d shifting=%b reject=%b, want speed=%0d gear=%0d shifting=%b reject=%b",
                         i, speed, gear, shifting, shift_reject, q[i].s, q[i].gr, q[i].sh, q[i].rj);
            end
        end
        q.delete();
    endtask

    task automatic test_manual_reject();
        for (int k = 1; k <= 8; k++) push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, (40 + 3 * k > 60) ? 60 : 40 + 3 * k, 2, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 60, 2, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 60, 2, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 60, 3, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 60 + 2 * k, 3, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 70, 3, 1'b0, 1'b1);
        push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 70, 3, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 70 - 2 * k, 3, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 58, 3, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 58, 3, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 58, 2, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 58, 2, 1'b0, 1'b1);
        push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 58, 2, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 58 - 2 * k, 2, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 26, 2, 1'b1, 1'b0);
        push(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 26, 2, 1'b1, 1'b1);
        push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 26, 1, 1'b0, 1'b0);
        foreach (q[i]) begin
            gas = q[i].g; brake = q[i].b; manual_mode = q[i].m;
            shift_up_req = q[i].u; shift_down_req = q[i].d;
            tick();
            n_tests++;
            if (speed !== 7'(q[i].s) || gear !== 3'(q[i].gr) || shifting !== q[i].sh || shift_reject !== q[i].rj) begin
                n_fail++;
                $display("FAIL manual_reject step %0d: got speed=%0d gear=%0d shifting=%b reject=%b, want speed=%0d gear=%0d shifting=%b reject=%b",
                         i, speed, gear, shifting, shift_reject, q[i].s, q[i].gr, q[i].sh, q[i].rj);
            end
        end
        q.delete();
    endtask

    task automatic test_coast();
        apply_reset();
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (k == 8) ? 9 : 10, 1, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (k == 8) ? 8 : 9, 1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13, 1, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (k == 8) ? 12 : 13, 1, 1'b0, 1'b0);
        foreach (q[i]) begin
            gas = q[i].g; brake = q[i].b; manual_mode = q[i].m;
            shift_up_req = q[i].u; shift_down_req = q[i].d;
            tick();
            n_tests++;
            if (speed !== 7'(q[i].s) || gear !== 3'(q[i].gr) || shifting !== q[i].sh || shift_reject !== q[i].rj) begin
                n_fail++;
                $display("FAIL coast step %0d: got speed=%0d gear=%0d shifting=%b reject=%b, want speed=%0d gear=%0d shifting=%b reject=%b",
                         i, speed, gear, shifting, shift_reject, q[i].s, q[i].gr, q[i].sh, q[i].rj);
            end
        end
        q.delete();
    endtask

    task automatic test_reset_mid_shift();
        apply_reset();
        for (int i = 1; i <= 8; i++) push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5 * i, 1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40, 1, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40, 1, 1'b1, 1'b0);
        foreach (q[i]) begin
            gas = q[i].g; brake = q[i].b; manual_mode = q[i].m;
            shift_up_req = q[i].u; shift_down_req = q[i].d;
            tick();
            n_tests++;
            if (speed !== 7'(q[i].s) || gear !== 3'(q[i].gr) || shifting !== q[i].sh || shift_reject !== q[i].rj) begin
                n_fail++;
                $display("FAIL mid_shift_setup step %0d: got speed=%0d gear=%0d shifting=%b reject=%b, want speed=%0d gear=%0d shifting=%b reject=%b",
                         i, speed, gear, shifting, shift_reject, q[i].s, q[i].gr, q[i].sh, q[i].rj);
            end
        end
        q.delete();
        reset = 1'b1;
        #1;
        n_tests++;
        if ({speed, gear, shifting, shift_reject} !== {7'd0, 3'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_shift_reset: got speed=%0d gear=%0d shifting=%b reject=%b, want 0 1 0 0",
                     speed, gear, shifting, shift_reject);
        end
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0);
        foreach (q[i]) begin
            gas = q[i].g; brake = q[i].b; manual_mode = q[i].m;
            shift_up_req = q[i].u; shift_down_req = q[i].d;
            tick();
            n_tests++;
            if (speed !== 7'(q[i].s) || gear !== 3'(q[i].gr) || shifting !== q[i].sh || shift_reject !== q[i].rj) begin
                n_fail++;
                $display("FAIL after_mid_shift_reset step %0d: got speed=%0d gear=%0d shifting=%b reject=%b, want speed=%0d gear=%0d shifting=%b reject=%b",
                         i, speed, gear, shifting, shift_reject, q[i].s, q[i].gr, q[i].sh, q[i].rj);
            end
        end
        q.delete();
    endtask

    task automatic test_top_gear_both_pedals();
        gas = 1'b1; brake = 1'b0; manual_mode = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (speed == 7'd100 && gear == 3'd4) break;
        end
        n_tests++;
        if ({speed, gear, shifting} !== {7'd100, 3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL reach_top_gear: got speed=%0d gear=%0d shifting=%b, want speed=100 gear=4 shifting=0",
                     speed, gear, shifting);
        end
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 100, 4, 1'b0, 1'b0);
        push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 99, 4, 1'b0, 1'b0);
        push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 98, 4, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 97, 4, 1'b0, 1'b0);
        foreach (q[i]) begin
            gas = q[i].g; brake = q[i].b; manual_mode = q[i].m;
            shift_up_req = q[i].u; shift_down_req = q[i].d;
            tick();
            n_tests++;
            if (speed !== 7'(q[i].s) || gear !== 3'(q[i].gr) || shifting !== q[i].sh || shift_reject !== q[i].rj) begin
                n_fail++;
                $display("FAIL top_gear step %0d: got speed=%0d gear=%0d shifting=%b reject=%b, want speed=%0d gear=%0d shifting=%b reject=%b",
                         i, speed, gear, shifting, shift_reject, q[i].s, q[i].gr, q[i].sh, q[i].rj);
            end
        end
        q.delete();
    endtask

    initial begin
        test_reset();
        test_auto_upshift();
        test_auto_downshift();
        test_manual_limiter();
        test_manual_reject();
        test_coast();
        test_reset_mid_shift();
        test_top_gear_both_pedals();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
